// File: rtl/regfile_rdp.sv
// Two-read/one-write register file with same-cycle write bypass and hard-wired $0.
// Optional post-reset clearing sequencer selected by REGFILE_CLEAR_EN.
module regfile_rdp #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int REG_NUM = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic              ready,
  output logic [0:0]        o_dbg_state
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  // Entry 0 is never written; reads of address 0 are forced to zero below.
  logic [DATA_W-1:0] r_mem [0:REG_NUM-1];
  logic              r_ready;
  logic [0:0]        w_state;
  logic              w_wr_en;

`ifdef REGFILE_CLEAR_EN
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_NUM - 1);

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              w_clr_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= ADDR_W'(1);
      r_ready   <= 1'b0;
    end else if (r_state == ST_CLEAR) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
      if (r_clr_cnt == LAST_IDX) begin
        r_state <= ST_READY;
        r_ready <= 1'b1;
      end
    end
  end

  assign w_state  = r_state;
  assign w_clr_en = !rst && (r_state == ST_CLEAR);
  // Writes arriving while clearing are dropped, not deferred.
  assign w_wr_en  = !rst && (r_state == ST_READY) && we && (waddr != '0);

  always_ff @(posedge clk) begin
    if (w_clr_en) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_wr_en) begin
      r_mem[waddr] <= wdata;
    end
  end
`else
  // Without the sequencer the file is usable on the first edge after reset
  // and keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready <= 1'b0;
    end else begin
      r_ready <= 1'b1;
    end
  end

  assign w_state = ST_READY;
  assign w_wr_en = !rst && we && (waddr != '0);

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[waddr] <= wdata;
    end
  end
`endif

  // Read priority: reset, disabled, $0, not ready, bypass, array.
  function automatic logic [DATA_W-1:0] f_read(
    input logic              en,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] mem_data
  );
    logic [DATA_W-1:0] v;
    v = '0;
    if (rst || !en || (addr == '0) || !r_ready) begin
      v = '0;
    end else if (we && (waddr == addr)) begin
      v = wdata;
    end else begin
      v = mem_data;
    end
    return v;
  endfunction

  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  always_comb begin
    w_rd1 = f_read(re1, raddr1, r_mem[raddr1]);
    w_rd2 = f_read(re2, raddr2, r_mem[raddr2]);
  end

  assign rdata1      = w_rd1;
  assign rdata2      = w_rd2;
  assign ready       = r_ready;
  assign o_dbg_state = w_state;

endmodule

// File: tb/tb_regfile_rdp.sv
// Randomized scoreboard bench for regfile_rdp; expected read data comes from an
// array model of the register file, covering both REGFILE_CLEAR_EN builds.
module tb_regfile_rdp;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          we = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic          re1 = 1'b0;
  logic [AW-1:0] raddr1 = '0;
  logic [DW-1:0] rdata1;
  logic          re2 = 1'b0;
  logic [AW-1:0] raddr2 = '0;
  logic [DW-1:0] rdata2;
  logic          ready;
  logic [0:0]    dbg_state;

  regfile_rdp #(.DATA_W(DW), .ADDR_W(AW), .REG_NUM(NREG)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .ready(ready), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference model: register contents, readiness and clear progress.
  logic [DW-1:0] m_mem [NREG];
  logic          m_ready = 1'b0;
  int            m_clr = 0;

  logic [2*DW:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expectation per driven cycle, sampled mid-cycle.
  always @(negedge clk) begin
    logic [2*DW:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ready", {31'b0, ready}, {31'b0, e[2*DW]});
      chk("rdata1", rdata1, e[2*DW-1:DW]);
      chk("rdata2", rdata2, e[DW-1:0]);
    end
  end

  function automatic logic [DW-1:0] exp_rd(input logic r, input logic e, input logic [AW-1:0] a,
                                           input logic w, input logic [AW-1:0] wa,
                                           input logic [DW-1:0] wd);
    if (r || !e || a == 0 || !m_ready) return '0;
    if (w && wa == a) return wd;
    return m_mem[a];
  endfunction

  task automatic model_edge(input logic r, input logic w, input logic [AW-1:0] wa,
                            input logic [DW-1:0] wd);
    if (r) begin
      m_ready = 1'b0;
      m_clr   = 0;
    end else begin
`ifdef REGFILE_CLEAR_EN
      if (!m_ready) begin
        m_clr++;
        if (m_clr == NREG - 1) begin
          for (int i = 0; i < NREG; i++) m_mem[i] = '0;
          m_ready = 1'b1;
        end
      end else if (w && wa != 0) begin
        m_mem[wa] = wd;
      end
`else
      if (w && wa != 0) m_mem[wa] = wd;
      m_ready = 1'b1;
`endif
    end
  endtask

  // Driver: one call drives one full clock cycle and queues its expectation.
  task automatic cyc(input logic r, input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input logic e1, input logic [AW-1:0] a1, input logic e2, input logic [AW-1:0] a2);
    rst = r; we = w; waddr = wa; wdata = wd;
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
    exp_q.push_back({m_ready, exp_rd(r, e1, a1, w, wa, wd), exp_rd(r, e2, a2, w, wa, wd)});
    @(posedge clk);
    model_edge(r, w, wa, wd);
    #1;
  endtask

  task automatic idle_read(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    cyc(1'b0, 1'b0, '0, '0, 1'b1, a1, 1'b1, a2);
  endtask

  initial begin
    logic [AW-1:0] wa, a1, a2;
    logic [DW-1:0] wd;
    for (int i = 0; i < NREG; i++) m_mem[i] = '0;
    @(posedge clk);
    #1;
    // Reset held for two cycles, reads enabled: everything must be zero.
    cyc(1'b1, 1'b1, 5'd3, 32'h1, 1'b1, 5'd3, 1'b1, 5'd17);
    cyc(1'b1, 1'b0, '0, '0, 1'b1, 5'd17, 1'b1, 5'd3);
`ifdef REGFILE_CLEAR_EN
    for (int i = 0; i < NREG; i++) idle_read(5'd17, 5'd1);
`else
    idle_read(5'd17, 5'd1);
`endif
    // Give every register a known value before random reads.
    for (int i = 1; i < NREG; i++)
      cyc(1'b0, 1'b1, AW'(i), $urandom, 1'b1, AW'($urandom_range(0, i)), 1'b1, AW'(i));

    cyc(1'b0, 1'b1, 5'd5, 32'h1234_5678, 1'b1, 5'd5, 1'b0, '0);
    cyc(1'b0, 1'b0, '0, '0, 1'b1, 5'd5, 1'b0, '0);
    cyc(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b1, 5'd0);
    cyc(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 5'd0);
    cyc(1'b0, 1'b1, 5'd3, 32'hA5A5_0000, 1'b0, '0, 1'b0, '0);
    cyc(1'b0, 1'b1, 5'd9, 32'h0000_5A5A, 1'b1, 5'd3, 1'b1, 5'd9);
    idle_read(5'd3, 5'd9);
    cyc(1'b0, 1'b0, '0, '0, 1'b0, 5'd3, 1'b1, 5'd9);
    cyc(1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b1, 5'd7, 1'b0, '0);
    cyc(1'b0, 1'b1, 5'd4, 32'hCAFE_F00D, 1'b1, 5'd7, 1'b1, 5'd4);
    cyc(1'b1, 1'b0, '0, '0, 1'b1, 5'd7, 1'b1, 5'd4);
`ifdef REGFILE_CLEAR_EN
    cyc(1'b0, 1'b1, 5'd8, 32'h1111_2222, 1'b1, 5'd7, 1'b1, 5'd8);
    for (int i = 0; i < NREG; i++) idle_read(5'd7, 5'd8);
`else
    idle_read(5'd4, 5'd7);
    idle_read(5'd4, 5'd7);
`endif

    // Random traffic; reads often target the write address to hit the bypass.
    for (int n = 0; n < 500; n++) begin
      wa = AW'($urandom_range(0, NREG - 1));
      wd = $urandom;
      a1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, NREG - 1));
      a2 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, NREG - 1));
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, wa, wd,
          $urandom_range(0, 3) != 0, a1, $urandom_range(0, 3) != 0, a2);
    end
    idle_read(5'd1, 5'd31);

    @(negedge clk);
    #1;
    chk("drain", DW'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_rdp.md
Name: regfile_rdp

Overview:
- General-purpose register file serving the decode stage. It answers two combinational read requests per cycle (enable plus address) and accepts one write per cycle from write-back.
- It returns the operand data that decode forwards to execute.
- It adds a write-to-read bypass, a hard-wired $0, and an optional post-reset clearing sequencer with a ready handshake.
- It sits between write-back and decode.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width.
- REG_NUM, 32, number of registers; must equal 2**ADDR_W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- we  input  1  write enable from write-back.
- waddr  input  ADDR_W  write register address.
- wdata  input  DATA_W  write data.
- re1  input  1  read port 1 enable.
- raddr1  input  ADDR_W  read port 1 address.
- rdata1  output  DATA_W  read port 1 data (combinational).
- re2  input  1  read port 2 enable.
- raddr2  input  ADDR_W  read port 2 address.
- rdata2  output  DATA_W  read port 2 data (combinational).
- ready  output  1  register file initialised and accepting writes.

Behaviour:
- FSM states: CLEAR, READY. State register and clr_cnt (ADDR_W bits) are updated on rising clk only.
- Reset (rst=1 at an edge):
  - With REGFILE_CLEAR_EN: state<=CLEAR, clr_cnt<=1, ready<=0.
  - Without it: state<=READY, ready<=0 on that edge; ready<=1 on the first edge with rst=0.
- Reset does not touch array contents except through the CLEAR sequence. Reset mid-clear restarts the sequence at clr_cnt=1.
- CLEAR, each edge with rst=0:
  - mem[clr_cnt]<=0 and clr_cnt<=clr_cnt+1.
  - On the edge that writes clr_cnt==REG_NUM-1: state<=READY, ready<=1.
  - ready therefore rises on the 31st edge after rst deasserts.
- Writes during CLEAR are dropped, not queued.
- READY write: on an edge with we=1, waddr!=0 and rst=0, mem[waddr]<=wdata. Writes to address 0 are ignored.
- mem[0] is never stored; reads of address 0 always return 0.
- Read port n, combinational, priority order:
  1. rst=1 → 0.
  2. ren=0 → 0.
  3. raddrn==0 → 0.
  4. ready=0 → 0.
  5. we=1 and waddr==raddrn → wdata (same-cycle bypass).
  6. Otherwise → mem[raddrn].
- Both ports are independent. Both may read the same address, and both may bypass simultaneously.
- Latency: read 0 cycles. Write becomes visible the same cycle via bypass and from the array on the next cycle.
- Simultaneous write plus read of the same register in the cycle ready first rises: bypass applies only once ready=1.
- No X on outputs after reset when REGFILE_CLEAR_EN is defined.

Optional Feature:
- Macro REGFILE_CLEAR_EN.
- Defined: CLEAR sequencer present; all registers read 0 after ready rises; ready latency is REG_NUM-1 cycles after reset release.
- Undefined: no CLEAR state or clr_cnt; ready is 1 one cycle after reset release; array contents are retained across reset (undefined at power-up).

Test Plan:
- CLEAR_EN defined: rst high 2 cycles, then low → ready=0 for 30 edges, 1 on the 31st. Then re1=1, raddr1=17 → rdata1=0x00000000.
- After ready: we=1, waddr=5, wdata=0x1234_5678, with re1=1, raddr1=5 in the same cycle → rdata1=0x12345678 (bypass). Next cycle with we=0 → still 0x12345678 from the array.
- we=1, waddr=0, wdata=0xFFFF_FFFF; next cycle re2=1, raddr2=0 → rdata2=0. Bypass also yields 0 in the write cycle.
- Reg 3 =0xA5A5_0000 and reg 9 =0x0000_5A5A: re1/raddr1=3 and re2/raddr2=9 → 0xA5A50000 and 0x00005A5A. Then re1=0 → rdata1=0.
- Write reg 7 =0xDEAD_BEEF, then rst for 1 cycle, then release; during CLEAR, re1/raddr1=7 → 0 and a write to reg 8 is dropped. After ready: reg 7 → 0, reg 8 → 0.
- CLEAR_EN undefined: write reg 4 =0xCAFE_F00D, then rst 1 cycle → ready=1 one edge after release; reg 4 reads 0xCAFEF00D.
